// File: rtl/mcpu_core_scoreboard_mlane_pkg.sv
// mcpu_core_scoreboard_mlane_pkg: shared widths and per-resource flag bundle for the scoreboard
package mcpu_core_scoreboard_mlane_pkg;
  localparam int PW = 2;
  typedef struct packed {
    logic busy;
    logic near_full;
    logic ovf;
    logic unf;
  } sb_flags_t;
endpackage

// File: rtl/mcpu_core_scoreboard_mlane_counter.sv
// mcpu_core_scoreboard_mlane_counter: in-flight write counter for one tracked register or predicate
module mcpu_core_scoreboard_mlane_counter #(
  parameter int NLANES = 4,
  parameter int CNT_W = 2,
  parameter int RW = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [RW-1:0]        idx,
  input  logic                 iss_valid,
  input  logic [NLANES-1:0]    iss_we,
  input  logic [NLANES*RW-1:0] iss_num,
  input  logic [NLANES-1:0]    wb_we,
  input  logic [NLANES*RW-1:0] wb_num,
  input  logic                 flush,
  output logic                 busy,
  output logic                 near_full,
  output logic                 ovf,
  output logic                 unf
);
  localparam int SW = CNT_W + 2;
  localparam int MAXCNT = 2**CNT_W - 1;
  // a threshold of 0 would hold the stall forever on an idle scoreboard, so it is clamped to 1
  localparam int FULL_AT = (MAXCNT - NLANES + 1 > 1) ? MAXCNT - NLANES + 1 : 1;
  logic [CNT_W-1:0] cnt;
  logic [SW-1:0] inc, dec;
  logic signed [SW-1:0] nxt;
  // count matching issue lanes and writeback ports, then form the signed next count
  always_comb begin
    inc = '0;
    dec = '0;
    for (int l = 0; l < NLANES; l++) begin
      inc = inc + SW'(iss_valid && iss_we[l] && iss_num[l*RW +: RW] == idx);
      dec = dec + SW'(wb_we[l] && wb_num[l*RW +: RW] == idx);
    end
    nxt = $signed({2'b00, cnt} + inc - dec);
    ovf = !flush && int'(nxt) > MAXCNT;
    unf = !flush && nxt[SW-1];
  end
  // flush discards everything; out-of-range results clamp to the nearest legal count
  always_ff @(posedge clk)
    cnt <= (!rst_n || flush) ? '0 : ovf ? CNT_W'(MAXCNT) : unf ? '0 : nxt[CNT_W-1:0];
  assign busy = |cnt;
  assign near_full = int'(cnt) >= FULL_AT;
endmodule

// File: rtl/mcpu_core_scoreboard_mlane.sv
// mcpu_core_scoreboard_mlane: multi-lane GPR/predicate scoreboard driving decode's dependency stall
module mcpu_core_scoreboard_mlane
  import mcpu_core_scoreboard_mlane_pkg::*;
#(
  parameter int NLANES = 4,
  parameter int NREGS = 32,
  parameter int NPREDS = 3,
  parameter int CNT_W = 2,
  localparam int RW = $clog2(NREGS)
) (
  input  logic                 clkrst_core_clk,
  input  logic                 clkrst_core_rst_n,
  input  logic                 iss_valid,
  input  logic [NLANES-1:0]    iss_rd_we,
  input  logic [NLANES*RW-1:0] iss_rd_num,
  input  logic [NLANES-1:0]    iss_pred_we,
  input  logic [NLANES*PW-1:0] iss_pred_num,
  input  logic [NLANES-1:0]    wb_rd_we,
  input  logic [NLANES*RW-1:0] wb_rd_num,
  input  logic [NLANES-1:0]    wb_pred_we,
  input  logic [NLANES*PW-1:0] wb_pred_num,
  input  logic                 flush,
  output logic [NREGS-1:0]     sb2d_reg_scoreboard,
  output logic [NPREDS-1:0]    sb2d_pred_scoreboard,
  output logic                 sb_full,
  output logic                 sb_err
);
  localparam int NT = NREGS + NPREDS;
  sb_flags_t fl [NT];
  logic any_err;
  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    mcpu_core_scoreboard_mlane_counter #(.NLANES(NLANES), .CNT_W(CNT_W), .RW(RW)) u_cnt (
      .clk(clkrst_core_clk), .rst_n(clkrst_core_rst_n), .idx(RW'(i)),
      .iss_valid(iss_valid), .iss_we(iss_rd_we), .iss_num(iss_rd_num),
      .wb_we(wb_rd_we), .wb_num(wb_rd_num), .flush(flush),
      .busy(fl[i].busy), .near_full(fl[i].near_full), .ovf(fl[i].ovf), .unf(fl[i].unf)
    );
    assign sb2d_reg_scoreboard[i] = fl[i].busy;
  end
  // predicate indices at or above NPREDS (including always-true) have no counter and match nothing
  for (genvar i = 0; i < NPREDS; i++) begin : g_pred
    mcpu_core_scoreboard_mlane_counter #(.NLANES(NLANES), .CNT_W(CNT_W), .RW(PW)) u_cnt (
      .clk(clkrst_core_clk), .rst_n(clkrst_core_rst_n), .idx(PW'(i)),
      .iss_valid(iss_valid), .iss_we(iss_pred_we), .iss_num(iss_pred_num),
      .wb_we(wb_pred_we), .wb_num(wb_pred_num), .flush(flush),
      .busy(fl[NREGS+i].busy), .near_full(fl[NREGS+i].near_full),
      .ovf(fl[NREGS+i].ovf), .unf(fl[NREGS+i].unf)
    );
    assign sb2d_pred_scoreboard[i] = fl[NREGS+i].busy;
  end
  // reduce per-resource flags into the shared stall and error indications
  always_comb begin
    sb_full = 1'b0;
    any_err = 1'b0;
    for (int k = 0; k < NT; k++) begin
      sb_full = sb_full | fl[k].near_full;
      any_err = any_err | fl[k].ovf | fl[k].unf;
    end
  end
  // error flag is sticky until reset; flush does not clear it
  always_ff @(posedge clkrst_core_clk)
    sb_err <= !clkrst_core_rst_n ? 1'b0 : sb_err | any_err;
endmodule

// File: tb/tb_mcpu_core_scoreboard_mlane.sv
// tb_mcpu_core_scoreboard_mlane: directed self-checking bench for the multi-lane scoreboard
module tb_mcpu_core_scoreboard_mlane;
  logic clk = 1'b0;
  logic rst_n;
  logic iss_valid;
  logic [3:0] iss_rd_we, iss_pred_we, wb_rd_we, wb_pred_we;
  logic [19:0] iss_rd_num, wb_rd_num;
  logic [7:0] iss_pred_num, wb_pred_num;
  logic flush;
  logic [31:0] reg_sb;
  logic [2:0] pred_sb;
  logic full, err;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mcpu_core_scoreboard_mlane dut (
    .clkrst_core_clk(clk), .clkrst_core_rst_n(rst_n), .iss_valid(iss_valid),
    .iss_rd_we(iss_rd_we), .iss_rd_num(iss_rd_num),
    .iss_pred_we(iss_pred_we), .iss_pred_num(iss_pred_num),
    .wb_rd_we(wb_rd_we), .wb_rd_num(wb_rd_num),
    .wb_pred_we(wb_pred_we), .wb_pred_num(wb_pred_num), .flush(flush),
    .sb2d_reg_scoreboard(reg_sb), .sb2d_pred_scoreboard(pred_sb),
    .sb_full(full), .sb_err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    iss_valid = 1'b0; flush = 1'b0;
    iss_rd_we = '0; iss_pred_we = '0; wb_rd_we = '0; wb_pred_we = '0;
    iss_rd_num = '0; iss_pred_num = '0; wb_rd_num = '0; wb_pred_num = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic irdl(input int l, input logic [4:0] r);
    iss_valid = 1'b1; iss_rd_we[l] = 1'b1; iss_rd_num[l*5 +: 5] = r;
  endtask

  task automatic wrdl(input int l, input logic [4:0] r);
    wb_rd_we[l] = 1'b1; wb_rd_num[l*5 +: 5] = r;
  endtask

  task automatic ipl(input int l, input logic [1:0] p);
    iss_valid = 1'b1; iss_pred_we[l] = 1'b1; iss_pred_num[l*2 +: 2] = p;
  endtask

  task automatic wpl(input int l, input logic [1:0] p);
    wb_pred_we[l] = 1'b1; wb_pred_num[l*2 +: 2] = p;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    step(); step();
    chk("rst_reg", reg_sb, 32'h0);
    chk("rst_pred", {29'd0, pred_sb}, 32'h0);
    chk("rst_full", {31'd0, full}, 32'h0);
    chk("rst_err", {31'd0, err}, 32'h0);
    rst_n = 1'b1;
    // single issue and retire, plus top register on lane 3
    irdl(0, 5'd5); irdl(3, 5'd31);
    step();
    chk("iss_r5_r31", reg_sb, 32'h8000_0020);
    wrdl(0, 5'd5); wrdl(3, 5'd31);
    step();
    chk("wb_r5_r31", reg_sb, 32'h0);
    // issue fields ignored when not valid
    iss_rd_we[0] = 1'b1; iss_rd_num[4:0] = 5'd3;
    step();
    chk("invalid_iss", reg_sb, 32'h0);
    // three lanes to one destination
    irdl(0, 5'd7); irdl(1, 5'd7); irdl(2, 5'd7);
    step();
    chk("r7_x3", reg_sb, 32'h80);
    chk("r7_full", {31'd0, full}, 32'h1);
    wrdl(1, 5'd7); step();
    chk("r7_wb1", reg_sb, 32'h80);
    wrdl(1, 5'd7); step();
    chk("r7_wb2", reg_sb, 32'h80);
    wrdl(1, 5'd7); step();
    chk("r7_wb3", reg_sb, 32'h0);
    chk("r7_err", {31'd0, err}, 32'h0);
    // same-cycle issue and retire net to zero
    irdl(0, 5'd9); step();
    irdl(1, 5'd9); wrdl(2, 5'd9); step();
    chk("r9_net", reg_sb, 32'h200);
    wrdl(0, 5'd9); step();
    chk("r9_drain", reg_sb, 32'h0);
    chk("r9_err", {31'd0, err}, 32'h0);
    // always-true predicate is never tracked
    ipl(0, 2'd2); ipl(1, 2'd3); step();
    chk("pred_iss", {29'd0, pred_sb}, 32'h4);
    wpl(0, 2'd2); wpl(1, 2'd3); step();
    chk("pred_wb", {29'd0, pred_sb}, 32'h0);
    chk("pred_err", {31'd0, err}, 32'h0);
    // flush beats same-cycle issue and an otherwise-underflowing retire
    irdl(0, 5'd1); irdl(1, 5'd4); ipl(2, 2'd0); step();
    chk("load_reg", reg_sb, 32'h12);
    chk("load_pred", {29'd0, pred_sb}, 32'h1);
    flush = 1'b1; irdl(0, 5'd2); wrdl(0, 5'd20); step();
    chk("flush_reg", reg_sb, 32'h0);
    chk("flush_pred", {29'd0, pred_sb}, 32'h0);
    chk("flush_err", {31'd0, err}, 32'h0);
    // underflow sets sticky error
    wrdl(0, 5'd12); step();
    chk("unf_reg", reg_sb, 32'h0);
    chk("unf_err", {31'd0, err}, 32'h1);
    flush = 1'b1; step();
    chk("unf_sticky", {31'd0, err}, 32'h1);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("rst_clr_err", {31'd0, err}, 32'h0);
    // overflow saturates at 3
    irdl(0, 5'd10); irdl(1, 5'd10); irdl(2, 5'd10); irdl(3, 5'd10); step();
    chk("ovf_reg", reg_sb, 32'h400);
    chk("ovf_err", {31'd0, err}, 32'h1);
    chk("ovf_full", {31'd0, full}, 32'h1);
    wrdl(0, 5'd10); wrdl(1, 5'd10); wrdl(2, 5'd10); step();
    chk("ovf_sat", reg_sb, 32'h0);
    chk("ovf_sticky", {31'd0, err}, 32'h1);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("final_err", {31'd0, err}, 32'h0);
    chk("final_full", {31'd0, full}, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
